count_display_driver: RTL and testbench

//  Downstream consumer of the 4-bit up/down counter. Samples the counter value
//  and splits it into two BCD digits (00..15). Drives a 2-digit, time-multiplexed

---
 rtl/cnt_disp_pkg.sv | 44 ++++
 rtl/seg7_decode.sv | 31 +++
 rtl/count_display_driver.sv | 110 +++++++++++
 tb/tb_count_display_driver.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnt_disp_pkg.sv
// Shared constants and helpers for the counter display driver:
// seven-segment codes, digit enables and the binary-to-BCD split.
package cnt_disp_pkg;

   localparam int unsigned DIGIT_W = 4;
   localparam int unsigned SEG_W   = 7;
   localparam int unsigned AN_W    = 2;

   // Segment order {g,f,e,d,c,b,a}, active-high
   localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
   localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
   localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
   localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
   localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
   localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
   localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
   localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
   localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
   localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
   localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;
   localparam logic [SEG_W-1:0] SEG_DASH  = 7'h40;

   localparam logic [AN_W-1:0] AN_ONES = 2'b01;
   localparam logic [AN_W-1:0] AN_TENS = 2'b10;

   typedef struct packed {
      logic [DIGIT_W-1:0] tens;
      logic [DIGIT_W-1:0] ones;
   } bcd_t;

   // 0..15 -> two BCD digits; tens is only ever 0 or 1
   function automatic bcd_t bcd_split(input logic [DIGIT_W-1:0] value);
      bcd_t r;
      if (value >= DIGIT_W'(10)) begin
         r.tens = DIGIT_W'(1);
         r.ones = value - DIGIT_W'(10);
      end else begin
         r.tens = '0;
         r.ones = value;
      end
      return r;
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to seven-segment decoder with a blanking input.
module seg7_decode
   import cnt_disp_pkg::*;
(
   input  logic [DIGIT_W-1:0] digit,
   input  logic               blank,
   output logic [SEG_W-1:0]   seg_c
);

   always_comb begin
      seg_c = SEG_DASH;
      if (blank) begin
         seg_c = SEG_BLANK;
      end else begin
         case (digit)
            4'd0:    seg_c = SEG_0;
            4'd1:    seg_c = SEG_1;
            4'd2:    seg_c = SEG_2;
            4'd3:    seg_c = SEG_3;
            4'd4:    seg_c = SEG_4;
            4'd5:    seg_c = SEG_5;
            4'd6:    seg_c = SEG_6;
            4'd7:    seg_c = SEG_7;
            4'd8:    seg_c = SEG_8;
            4'd9:    seg_c = SEG_9;
            default: seg_c = SEG_DASH;
         endcase
      end
   end

endmodule

// File: rtl/count_display_driver.sv
// Samples an up/down counter, drives a 2-digit multiplexed seven-segment
// display with tens blanking, and detects/counts counter wrap events.
module count_display_driver
   import cnt_disp_pkg::*;
#(
   parameter int unsigned REFRESH_DIV = 4,
   parameter int unsigned WRAP_W      = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [DIGIT_W-1:0] count_in,
   input  logic               up_down,
   output logic [SEG_W-1:0]   seg,
   output logic [AN_W-1:0]    an,
   output logic               wrap_pulse,
   output logic               wrap_dir,
   output logic [WRAP_W-1:0]  wrap_count
);

   localparam int unsigned DIV_W = 16;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

   logic [DIGIT_W-1:0] count_q;
   logic [DIGIT_W-1:0] prev_q;
   logic               dir_q;
   logic               samp_valid;
   logic               prev_valid;
   logic [DIV_W-1:0]   div_cnt;
   logic               sel;

   bcd_t               bcd_c;
   logic [DIGIT_W-1:0] digit_c;
   logic               blank_c;
   logic [SEG_W-1:0]   seg_next_c;
   logic               wrap_up_c;
   logic               wrap_dn_c;

   // Digit selection and tens blanking for the output register
   always_comb begin
      bcd_c   = bcd_split(count_q);
      digit_c = sel ? bcd_c.tens : bcd_c.ones;
      blank_c = sel && (bcd_c.tens == '0);
   end

   seg7_decode u_dec (
      .digit (digit_c),
      .blank (blank_c),
      .seg_c (seg_next_c)
   );

   // Direction is sampled alongside the value so it qualifies the same transition
   always_comb begin
      wrap_up_c = prev_valid && (prev_q == 4'd15) && (count_q == 4'd0)  &&  dir_q;
      wrap_dn_c = prev_valid && (prev_q == 4'd0)  && (count_q == 4'd15) && !dir_q;
   end

   // Sampler and refresh divider
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q    <= '0;
         prev_q     <= '0;
         dir_q      <= 1'b0;
         samp_valid <= 1'b0;
         prev_valid <= 1'b0;
         div_cnt    <= '0;
         sel        <= 1'b0;
      end else begin
         count_q    <= count_in;
         prev_q     <= count_q;
         dir_q      <= up_down;
         samp_valid <= 1'b1;
         prev_valid <= samp_valid;
         if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            sel     <= ~sel;
         end else begin
            div_cnt <= div_cnt + DIV_W'(1);
         end
      end
   end

   // Display output register
   always_ff @(posedge clk) begin
      if (reset) begin
         seg <= SEG_BLANK;
         an  <= AN_ONES;
      end else begin
         seg <= seg_next_c;
         an  <= sel ? AN_TENS : AN_ONES;
      end
   end

   // Wrap pulse, direction and saturating wrap counter
   always_ff @(posedge clk) begin
      if (reset) begin
         wrap_pulse <= 1'b0;
         wrap_dir   <= 1'b0;
         wrap_count <= '0;
      end else begin
         wrap_pulse <= wrap_up_c || wrap_dn_c;
         if (wrap_up_c || wrap_dn_c) begin
            wrap_dir <= wrap_up_c;
            if (wrap_count != '1) begin
               wrap_count <= wrap_count + WRAP_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_count_display_driver.sv
// Randomized and directed checks of count_display_driver against a
// sample-history reference model.
module tb_count_display_driver;

   localparam int RD = 4;
   localparam int WW = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic [3:0]    count_in;
   logic          up_down;
   logic [6:0]    seg;
   logic [1:0]    an;
   logic          wrap_pulse;
   logic          wrap_dir;
   logic [WW-1:0] wrap_count;

   count_display_driver #(.REFRESH_DIV(RD), .WRAP_W(WW)) dut (
      .clk        (clk),
      .reset      (reset),
      .count_in   (count_in),
      .up_down    (up_down),
      .seg        (seg),
      .an         (an),
      .wrap_pulse (wrap_pulse),
      .wrap_dir   (wrap_dir),
      .wrap_count (wrap_count)
   );

   always #5 clk = ~clk;

   logic [6:0] segtab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

   int vectors = 0;
   int miscompares = 0;

   // Reference model: edges since reset, last two samples and their direction
   int         n_edges = 0;
   int         nsamp = 0;
   int         q1 = 0;
   int         q2 = 0;
   bit         d1 = 0;
   logic [6:0] e_seg;
   logic [1:0] e_an;
   logic       e_pulse;
   logic       e_dir;
   int         e_cnt;

   // Drive one cycle of inputs, advance the model across the edge, settle
   task automatic tick(input int c, input bit ud, input bit r);
      int  sel;
      bit  w;
      count_in = 4'(c);
      up_down  = ud;
      reset    = r;
      @(posedge clk);
      if (r) begin
         e_seg = 7'h00; e_an = 2'b01; e_pulse = 0; e_dir = 0; e_cnt = 0;
         n_edges = 0; nsamp = 0; q1 = 0; q2 = 0; d1 = 0;
      end else begin
         sel = (n_edges / RD) % 2;
         if (sel == 1) begin
            e_an  = 2'b10;
            e_seg = (q1 >= 10) ? segtab[1] : 7'h00;
         end else begin
            e_an  = 2'b01;
            e_seg = segtab[q1 % 10];
         end
         w = (nsamp >= 2) && ((q2 == 15 && q1 == 0 && d1) || (q2 == 0 && q1 == 15 && !d1));
         e_pulse = w;
         if (w) begin
            e_dir = d1;
            if (e_cnt < (1 << WW) - 1) e_cnt++;
         end
         q2 = q1; q1 = c; d1 = ud; nsamp++; n_edges++;
      end
      #1;
   endtask

   task automatic test_reset();
      tick(9, 1, 1);
      tick(9, 1, 1);
      vectors++;
      if ({seg, an, wrap_pulse, wrap_dir, wrap_count} !== {7'h00, 2'b01, 1'b0, 1'b0, WW'(0)}) begin
         miscompares++;
         $display("FAIL reset: seg=%h an=%b pulse=%b dir=%b cnt=%0d, required seg=00 an=01 pulse=0 dir=0 cnt=0",
                  seg, an, wrap_pulse, wrap_dir, wrap_count);
      end
      tick(9, 1, 0);
      tick(9, 1, 0);
      vectors++;
      if (seg !== 7'h6F || an !== 2'b01) begin
         miscompares++;
         $display("FAIL reset_release: seg=%h an=%b, required seg=6F an=01", seg, an);
      end
   endtask

   task automatic test_refresh();
      tick(13, 1, 1);
      for (int i = 0; i < 4 * RD; i++) begin
         logic [6:0] want_seg;
         logic [1:0] want_an;
         tick(13, 1, 0);
         want_an  = ((i / RD) % 2 == 1) ? 2'b10 : 2'b01;
         want_seg = (i == 0) ? 7'h3F : ((want_an == 2'b10) ? 7'h06 : 7'h4F);
         vectors++;
         if (seg !== want_seg || an !== want_an || seg !== e_seg || an !== e_an) begin
            miscompares++;
            $display("FAIL refresh[%0d]: seg=%h an=%b, required seg=%h an=%b", i, seg, an, want_seg, want_an);
         end
      end
   endtask

   task automatic test_blanking();
      tick(5, 1, 1);
      for (int i = 0; i < 3 * RD; i++) begin
         tick(5, 1, 0);
         if (i >= 1) begin
            vectors++;
            if ((an === 2'b10 && seg !== 7'h00) || (an === 2'b01 && seg !== 7'h6D) || an !== e_an) begin
               miscompares++;
               $display("FAIL blanking[%0d]: seg=%h an=%b, required seg=%h an=%b", i, seg, an, e_seg, e_an);
            end
         end
      end
   endtask

   task automatic test_up_wrap();
      int seq[$];
      int pulses = 0;
      int pulse_at = -1;
      for (int v = 0; v < 16; v++) seq.push_back(v);
      seq.push_back(0); seq.push_back(1); seq.push_back(1); seq.push_back(1);
      tick(0, 1, 1);
      foreach (seq[i]) begin
         tick(seq[i], 1, 0);
         if (wrap_pulse === 1'b1) begin pulses++; pulse_at = i; end
         vectors++;
         if ({seg, an, wrap_pulse, wrap_dir, wrap_count} !== {e_seg, e_an, e_pulse, e_dir, WW'(e_cnt)}) begin
            miscompares++;
            $display("FAIL up_wrap[%0d]: seg=%h an=%b pulse=%b dir=%b cnt=%0d, required %h %b %b %b %0d",
                     i, seg, an, wrap_pulse, wrap_dir, wrap_count, e_seg, e_an, e_pulse, e_dir, e_cnt);
         end
      end
      vectors++;
      if (pulses != 1 || pulse_at != 17 || wrap_dir !== 1'b1 || wrap_count !== WW'(1)) begin
         miscompares++;
         $display("FAIL up_wrap_summary: pulses=%0d at=%0d dir=%b cnt=%0d, required 1 at 17 dir=1 cnt=1",
                  pulses, pulse_at, wrap_dir, wrap_count);
      end
   endtask

   task automatic test_down_wrap();
      int seq[$] = '{1, 0, 15, 15, 15, 0, 7, 3, 3, 3};
      int pulses = 0;
      foreach (seq[i]) begin
         tick(seq[i], 0, 0);
         if (wrap_pulse === 1'b1) pulses++;
         vectors++;
         if ({seg, an, wrap_pulse, wrap_dir, wrap_count} !== {e_seg, e_an, e_pulse, e_dir, WW'(e_cnt)}) begin
            miscompares++;
            $display("FAIL down_wrap[%0d]: seg=%h an=%b pulse=%b dir=%b cnt=%0d, required %h %b %b %b %0d",
                     i, seg, an, wrap_pulse, wrap_dir, wrap_count, e_seg, e_an, e_pulse, e_dir, e_cnt);
         end
      end
      vectors++;
      if (pulses != 1 || wrap_dir !== 1'b0 || wrap_count !== WW'(2)) begin
         miscompares++;
         $display("FAIL down_wrap_summary: pulses=%0d dir=%b cnt=%0d, required 1 dir=0 cnt=2",
                  pulses, wrap_dir, wrap_count);
      end
   endtask

   task automatic test_saturation();
      for (int k = 0; k < 5; k++) begin
         tick(15, 1, 0);
         tick(0, 1, 0);
         tick(0, 1, 0);
         vectors++;
         if (wrap_count !== WW'(e_cnt) || wrap_dir !== e_dir) begin
            miscompares++;
            $display("FAIL saturation[%0d]: cnt=%0d dir=%b, required cnt=%0d dir=%b", k, wrap_count, wrap_dir, e_cnt, e_dir);
         end
      end
      vectors++;
      if (wrap_count !== WW'(3)) begin
         miscompares++;
         $display("FAIL saturation_final: cnt=%0d, required 3", wrap_count);
      end
      tick(15, 1, 0);
      tick(0, 1, 1);
      vectors++;
      if ({seg, an, wrap_pulse, wrap_dir, wrap_count} !== {7'h00, 2'b01, 1'b0, 1'b0, WW'(0)}) begin
         miscompares++;
         $display("FAIL mid_reset: seg=%h an=%b pulse=%b dir=%b cnt=%0d, required 00 01 0 0 0",
                  seg, an, wrap_pulse, wrap_dir, wrap_count);
      end
      tick(0, 1, 0);
      tick(0, 1, 0);
      vectors++;
      if (wrap_pulse !== 1'b0 || wrap_count !== WW'(0)) begin
         miscompares++;
         $display("FAIL first_sample_no_wrap: pulse=%b cnt=%0d, required pulse=0 cnt=0", wrap_pulse, wrap_count);
      end
   endtask

   task automatic test_back_to_back();
      int c[4]  = '{15, 0, 15, 15};
      bit ud[4] = '{1, 1, 0, 0};
      int pulses = 0;
      tick(15, 1, 1);
      tick(15, 1, 0);
      foreach (c[i]) begin
         tick(c[i], ud[i], 0);
         if (wrap_pulse === 1'b1) pulses++;
         vectors++;
         if ({wrap_pulse, wrap_dir, wrap_count} !== {e_pulse, e_dir, WW'(e_cnt)}) begin
            miscompares++;
            $display("FAIL back_to_back[%0d]: pulse=%b dir=%b cnt=%0d, required %b %b %0d",
                     i, wrap_pulse, wrap_dir, wrap_count, e_pulse, e_dir, e_cnt);
         end
      end
      vectors++;
      if (pulses != 2 || wrap_count !== WW'(2) || wrap_dir !== 1'b0) begin
         miscompares++;
         $display("FAIL back_to_back_summary: pulses=%0d cnt=%0d dir=%b, required 2 2 0", pulses, wrap_count, wrap_dir);
      end
   endtask

   task automatic test_random();
      tick(0, 1, 1);
      for (int i = 0; i < 400; i++) begin
         int sel = $urandom_range(0, 3);
         int c   = (sel == 0) ? 0 : (sel == 1) ? 15 : $urandom_range(0, 15);
         bit ud  = 1'($urandom_range(0, 1));
         bit r   = ($urandom_range(0, 63) == 0);
         tick(c, ud, r);
         vectors++;
         if ({seg, an, wrap_pulse, wrap_dir, wrap_count} !== {e_seg, e_an, e_pulse, e_dir, WW'(e_cnt)}) begin
            miscompares++;
            $display("FAIL random[%0d]: seg=%h an=%b pulse=%b dir=%b cnt=%0d, required %h %b %b %b %0d",
                     i, seg, an, wrap_pulse, wrap_dir, wrap_count, e_seg, e_an, e_pulse, e_dir, e_cnt);
         end
      end
   endtask

   initial begin
      reset = 1'b1; count_in = '0; up_down = 1'b1;
      test_reset();
      test_refresh();
      test_blanking();
      test_up_wrap();
      test_down_wrap();
      test_saturation();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
